// File: rtl/counter_arb_pkg.sv
// Shared types and helpers for the counter arbiter: FSM state encoding,
// default sizes and the round-robin winner picker.
package counter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 5;
  localparam int MAXREQ   = 8;

  // One-hot winner: first set bit at or after rr, wrapping within nreq bits.
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] req,
                                                input logic [2:0] rr,
                                                input int nreq);
    logic [MAXREQ-1:0] pick;
    logic found;
    int idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAXREQ; i++) begin
      idx = (int'(rr) + i) % nreq;
      if (i < nreq && !found && req[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/shared_ctr.sv
// CW-bit up-counter shared by all requesters; clear has priority over enable.
module shared_ctr
  import counter_arb_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared counter to NREQ requesters for
// runs of len+1 counts. Define CNT_ABORT_EN to let an owner abort by dropping req.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [CW-1:0]      cnt_out,
  output logic [NREQ-1:0]    done,
  output logic [1:0]         fsm_state
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: req is a level held by the client; the arbiter samples it
  // only in IDLE, and grant stays asserted from the capture edge through
  // the single-cycle done pulse, dropping on the edge after done.
  state_t            state_q;
  logic [RRW-1:0]    rr;
  logic [CW-1:0]     tc_q;
  logic [MAXREQ-1:0] req_ext;
  logic [MAXREQ-1:0] pick;
  logic [NREQ-1:0]   win_oh;
  logic [RRW-1:0]    win_idx;
  logic [CW-1:0]     win_len;
  logic              clr;
  logic              en;

  always_comb begin
    req_ext = '0;
    req_ext[NREQ-1:0] = req;
    pick    = rr_pick(req_ext, 3'(rr), NREQ);
    win_oh  = pick[NREQ-1:0];
    win_idx = '0;
    for (int i = 0; i < MAXREQ; i++) begin
      if (pick[i]) win_idx = RRW'(i);
    end
    win_len = len[int'(win_idx)*CW +: CW];
  end

`ifdef CNT_ABORT_EN
  logic owner_req;
  assign owner_req = |(req & grant);
`endif

  // The counter only runs while below the captured terminal count, so it never wraps.
  always_comb begin
    clr = 1'b0;
    en  = 1'b0;
    case (state_q)
      IDLE: clr = 1'b1;
      RUN: begin
        en = (cnt_out != tc_q);
`ifdef CNT_ABORT_EN
        if (!owner_req) begin
          clr = 1'b1;
          en  = 1'b0;
        end
`endif
      end
      DONE:    clr = 1'b1;
      default: clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      rr      <= '0;
      tc_q    <= '0;
    end else begin
      done <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant   <= win_oh;
            tc_q    <= win_len;
            rr      <= (win_idx == RRW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
`ifdef CNT_ABORT_EN
          if (!owner_req) begin
            grant   <= '0;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else
`endif
          if (cnt_out == tc_q) begin
            done    <= grant;
            state_q <= DONE;
          end
        end
        DONE: begin
          grant   <= '0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          grant   <= '0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fsm_state = state_q;

  shared_ctr #(.CW(CW)) u_ctr (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .en   (en),
    .cnt  (cnt_out)
  );

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: a run-level reference model plans the expected
// per-cycle outputs into a queue; a monitor pops and compares every cycle.
module tb_counter_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 5;
  localparam int W    = 2 * NREQ + 1 + CW;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [CW-1:0]      cnt_out;
  logic [NREQ-1:0]    done;
  logic [1:0]         fsm_state;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] plan[$];
  logic [W-1:0] cur;
  int           m_rr;

  always #5 clk = ~clk;

  counter_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .len       (len),
    .grant     (grant),
    .busy      (busy),
    .cnt_out   (cnt_out),
    .done      (done),
    .fsm_state (fsm_state)
  );

  function automatic logic [W-1:0] pack(input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                                        input logic b, input logic [CW-1:0] c);
    return {g, d, b, c};
  endfunction

  // Reference model: on every edge the visible output is the next planned
  // cycle; when nothing is planned and someone requests, a whole grant
  // (len+1 run cycles, one done cycle, one idle cycle) is planned at once.
  always @(posedge clk) begin
    logic [NREQ-1:0] g;
    int w;
    int l;
    logic abort;
    if (!rstn) begin
      plan.delete();
      exp_q.delete();
      cur  = '0;
      m_rr = 0;
    end else begin
      abort = 1'b0;
`ifdef CNT_ABORT_EN
      if (cur[CW] && cur[CW+1 +: NREQ] == '0 && (req & cur[W-1 -: NREQ]) == '0) begin
        plan.delete();
        abort = 1'b1;
      end
`endif
      if (plan.size() == 0) begin
        if (!abort && req != '0) begin
          w = -1;
          for (int i = 0; i < NREQ; i++) begin
            if (w < 0 && req[(m_rr + i) % NREQ]) w = (m_rr + i) % NREQ;
          end
          g = '0;
          g[w] = 1'b1;
          l = int'(len[w*CW +: CW]);
          for (int i = 0; i <= l; i++) plan.push_back(pack(g, '0, 1'b1, CW'(i)));
          plan.push_back(pack(g, g, 1'b1, CW'(l)));
          plan.push_back(pack('0, '0, 1'b0, '0));
          m_rr = (w + 1) % NREQ;
        end else begin
          plan.push_back(pack('0, '0, 1'b0, '0));
        end
      end
      cur = plan.pop_front();
      exp_q.push_back(cur);
    end
  end

  // Monitor: compare DUT outputs against the planned cycle, away from the edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (rstn && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {grant, done, busy, cnt_out};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_out t=%0t got grant=%b done=%b busy=%b cnt=%0d expected grant=%b done=%b busy=%b cnt=%0d",
                 $time, grant, done, busy, cnt_out,
                 e[W-1 -: NREQ], e[CW+1 +: NREQ], e[CW], e[CW-1:0]);
      end
      tests++;
      if (!$onehot0(grant) || !$onehot0(done) || (done != '0 && grant !== done)) begin
        fails++;
        $display("FAIL invariant t=%0t got grant=%b done=%b expected onehot0 and done==grant",
                 $time, grant, done);
      end
    end
  end

  task automatic set_len(input int i, input int v);
    len[i*CW +: CW] = CW'(v);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if ({grant, done, busy, cnt_out} !== '0) begin
      fails++;
      $display("FAIL %s got grant=%b done=%b busy=%b cnt=%0d expected all zero",
               tag, grant, done, busy, cnt_out);
    end
  endtask

  task automatic wait_run_cnt(input logic [CW-1:0] v);
    int n;
    n = 0;
    while (!(busy && done == '0 && cnt_out == v) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      tests++;
      fails++;
      $display("FAIL wait_cnt timeout got cnt=%0d expected cnt=%0d within 60 cycles", cnt_out, v);
    end
  endtask

  initial begin
    rstn = 1'b0;
    req  = '0;
    len  = '0;
    run_cycles(2);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rstn = 1'b1;
    run_cycles(2);

    // Single run, len[0]=3.
    set_len(0, 3);
    req = 4'b0001;
    run_cycles(6);
    req = 4'b0000;
    run_cycles(6);

    // Round-robin with everyone requesting zero-length runs.
    len = '0;
    req = 4'b1111;
    run_cycles(16);
    req = 4'b0000;
    run_cycles(4);

    // Longest run: no wrap past the top count.
    set_len(1, 31);
    req = 4'b0010;
    run_cycles(3);
    req = 4'b0000;
    run_cycles(36);

    // Late arrival of req[2] and a len[0] change during req[0]'s run.
    set_len(0, 10);
    set_len(2, 2);
    req = 4'b0001;
    run_cycles(4);
    req = 4'b0101;
    set_len(0, 1);
    run_cycles(10);
    req = 4'b0100;
    run_cycles(10);
    req = 4'b0000;
    run_cycles(4);

    // Owner drops req at cnt_out=2.
    set_len(0, 6);
    req = 4'b0001;
    wait_run_cnt(CW'(2));
    req = 4'b0000;
    run_cycles(12);

    // Asynchronous reset in the middle of a run.
    set_len(0, 8);
    req = 4'b0001;
    wait_run_cnt(CW'(3));
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_run");
    len = {5'd2, 5'd2, 5'd2, 5'd2};
    req = 4'b1111;
    run_cycles(3);
    rstn = 1'b1;
    run_cycles(20);

    // Randomized traffic.
    req = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 7) == 0) set_len($urandom_range(0, NREQ - 1), 31);
        else set_len($urandom_range(0, NREQ - 1), $urandom_range(0, 6));
      end
    end

    req = '0;
    run_cycles(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
